// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared constants for the debug probe: source selects, glyph table, default timing
package dbg_pkg;

  localparam int DEF_REFRESH_DIV  = 100000;
  localparam int DEF_DEBOUNCE_CNT = 1000000;

  typedef enum logic [2:0] {
    SEL_PC    = 3'd0,
    SEL_INST  = 3'd1,
    SEL_RF    = 3'd2,
    SEL_MEM   = 3'd3,
    SEL_COP0  = 3'd4,
    SEL_HI    = 3'd5,
    SEL_LO    = 3'd6,
    SEL_BLANK = 3'd7
  } sel_e;

  // Active-low {g,f,e,d,c,b,a}; entry [n] is the glyph for hex digit n
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/dbg_btn.sv
// rtl/dbg_btn.sv - button conditioner: 2-flop synchronizer, optional debounce
// (DBG_PROBE_DEBOUNCE_EN), rising-edge detect producing one pulse per press
module dbg_btn
  import dbg_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  if (DEBOUNCE_CNT < 1) begin : g_bad_debounce_cnt
    $error("dbg_btn: DEBOUNCE_CNT must be at least 1");
  end

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic vld1_q, vld1_d;
  logic vld2_q, vld2_d;
  logic prev_q, prev_d;
  logic armed_q, armed_d;
  logic level;
  logic level_ok;

`ifdef DBG_PROBE_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stab_q, stab_d;

  always_comb begin
    cnt_d  = '0;
    stab_d = stab_q;
    if (sync2_q != stab_q) begin
      if (cnt_q == CW'(DEBOUNCE_CNT - 1)) begin
        stab_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      stab_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      stab_q <= stab_d;
    end
  end

  assign level = stab_q;
`else
  assign level = sync2_q;
`endif

  // A zero level only counts as a real release once the synchronizer holds
  // post-reset samples and the filtered level agrees with them; until then a
  // button held through reset cannot arm the edge detector.
  assign level_ok = vld2_q & (sync2_q == level);

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    vld1_d  = 1'b1;
    vld2_d  = vld1_q;
    prev_d  = level;
    armed_d = armed_q | (level_ok & ~level);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      vld1_q  <= vld1_d;
      vld2_q  <= vld2_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign pulse = armed_q & level & ~prev_q;

endmodule

// File: rtl/dbg_probe.sv
// rtl/dbg_probe.sv - CPU debug probe: button-stepped index, probe addresses, captured value on
// an 8-digit multiplexed seven-segment display; button debounce enabled by DBG_PROBE_DEBOUNCE_EN
module dbg_probe
  import dbg_pkg::*;
#(
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  sel,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic        freeze,
  output logic [4:0]  rf_addr,
  output logic [31:0] mem_addr,
  output logic [4:0]  cop_addr,
  input  logic [31:0] rf_data,
  input  logic [31:0] mem_data,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_inst,
  input  logic [31:0] cop_data,
  input  logic [31:0] hi_data,
  input  logic [31:0] lo_data,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic          up_pulse;
  logic          dn_pulse;
  logic [2:0]    sel_q, sel_d;
  logic [4:0]    idx_q, idx_d;
  logic [31:0]   disp_q, disp_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [2:0]    dig_q, dig_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic [31:0]   src;
  logic [3:0]    nib;

  dbg_btn #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_btn_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_up),
    .pulse (up_pulse)
  );

  dbg_btn #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_btn_dn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_dn),
    .pulse (dn_pulse)
  );

  // Source change resets the index so each view starts at entry 0
  always_comb begin
    sel_d = sel;
    idx_d = idx_q;
    if (sel != sel_q) begin
      idx_d = '0;
    end else if (up_pulse && !dn_pulse) begin
      idx_d = idx_q + 5'd1;
    end else if (dn_pulse && !up_pulse) begin
      idx_d = idx_q - 5'd1;
    end
  end

  always_comb begin
    case (sel_e'(sel))
      SEL_PC:    src = cpu_pc;
      SEL_INST:  src = cpu_inst;
      SEL_RF:    src = rf_data;
      SEL_MEM:   src = mem_data;
      SEL_COP0:  src = cop_data;
      SEL_HI:    src = hi_data;
      SEL_LO:    src = lo_data;
      default:   src = '0;
    endcase
    disp_d = freeze ? disp_q : src;
  end

  always_comb begin
    ref_d = ref_q + 1'b1;
    dig_d = dig_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      dig_d = dig_q + 3'd1;
    end
  end

  always_comb begin
    nib   = disp_q[{dig_q, 2'b00} +: 4];
    an_d  = ~(8'b1 << dig_q);
    seg_d = {~(freeze && (dig_q == 3'd7)), GLYPH_TABLE[nib]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      idx_q  <= '0;
      disp_q <= '0;
      ref_q  <= '0;
      dig_q  <= '0;
      an_q   <= 8'hFF;
      seg_q  <= 8'hFF;
    end else begin
      sel_q  <= sel_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      ref_q  <= ref_d;
      dig_q  <= dig_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign rf_addr  = idx_q;
  assign cop_addr = idx_q;
  assign mem_addr = {25'b0, idx_q, 2'b00};
  assign an       = an_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_dbg_probe.sv
// tb/tb_dbg_probe.sv - directed self-checking bench for dbg_probe
module tb_dbg_probe;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel;
  logic        btn_up;
  logic        btn_dn;
  logic        freeze;
  logic [4:0]  rf_addr;
  logic [31:0] mem_addr;
  logic [4:0]  cop_addr;
  logic [31:0] rf_data;
  logic [31:0] mem_data;
  logic [31:0] cpu_pc;
  logic [31:0] cpu_inst;
  logic [31:0] cop_data;
  logic [31:0] hi_data;
  logic [31:0] lo_data;
  logic [7:0]  an;
  logic [7:0]  seg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_data = 32'hA000_0000 | mem_addr;

  dbg_probe #(.REFRESH_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .btn_up   (btn_up),
    .btn_dn   (btn_dn),
    .freeze   (freeze),
    .rf_addr  (rf_addr),
    .mem_addr (mem_addr),
    .cop_addr (cop_addr),
    .rf_data  (rf_data),
    .mem_data (mem_data),
    .cpu_pc   (cpu_pc),
    .cpu_inst (cpu_inst),
    .cop_data (cop_data),
    .hi_data  (hi_data),
    .lo_data  (lo_data),
    .an       (an),
    .seg      (seg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic up, input logic dn, input int hold, input int rel);
    btn_up = up;
    btn_dn = dn;
    step(hold);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    step(rel);
  endtask

  task automatic wait_digit(input string tag, input logic [7:0] want_an, input logic [7:0] want_seg);
    for (int i = 0; i < 40; i++) begin
      if (an === want_an) break;
      step(1);
    end
    check({tag, "_an"}, {24'b0, an}, {24'b0, want_an});
    check({tag, "_seg"}, {24'b0, seg}, {24'b0, want_seg});
  endtask

  initial begin
    rst      = 1'b1;
    sel      = 3'd2;
    btn_up   = 1'b0;
    btn_dn   = 1'b0;
    freeze   = 1'b0;
    rf_data  = 32'h1234_ABCD;
    cpu_pc   = 32'h0;
    cpu_inst = 32'h0;
    cop_data = 32'h0;
    hi_data  = 32'h0;
    lo_data  = 32'h0;

    step(2);
    check("rst_an", {24'b0, an}, 32'h0000_00FF);
    check("rst_seg", {24'b0, seg}, 32'h0000_00FF);
    check("rst_rf_addr", {27'b0, rf_addr}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_cop_addr", {27'b0, cop_addr}, 32'd0);
    rst = 1'b0;
    step(4);

    // RF step: three up presses, then digit 0 shows 'd', digit 3 shows 'A'
    press(1'b1, 1'b0, 6, 8);
    press(1'b1, 1'b0, 6, 8);
    press(1'b1, 1'b0, 6, 8);
    check("rf_step_rf_addr", {27'b0, rf_addr}, 32'd3);
    check("rf_step_cop_addr", {27'b0, cop_addr}, 32'd3);
    check("rf_step_mem_addr", mem_addr, 32'h0000_000C);
    wait_digit("rf_dig0", 8'hFE, 8'hA1);
    wait_digit("rf_dig3", 8'hF7, 8'h88);

    // Simultaneous up+down leaves the index alone
    press(1'b1, 1'b1, 6, 8);
    check("simul_rf_addr", {27'b0, rf_addr}, 32'd3);

    // Mode change clears the index on the next edge
    sel = 3'd3;
    check("selchg_before_edge", {27'b0, rf_addr}, 32'd3);
    step(1);
    check("selchg_after_edge", {27'b0, rf_addr}, 32'd0);
    wait_digit("mem_dig7", 8'h7F, 8'h88);

    // Wrap down from 0 and back up
    sel = 3'd2;
    step(2);
    check("wrap_start", {27'b0, rf_addr}, 32'd0);
    press(1'b0, 1'b1, 6, 8);
    check("wrap_dn_rf_addr", {27'b0, rf_addr}, 32'd31);
    check("wrap_dn_mem_addr", mem_addr, 32'h0000_007C);
    check("wrap_dn_cop_addr", {27'b0, cop_addr}, 32'd31);
    press(1'b1, 1'b0, 6, 8);
    check("wrap_up_rf_addr", {27'b0, rf_addr}, 32'd0);

    // Freeze holds the captured PC and lights dp on digit 7
    sel    = 3'd0;
    cpu_pc = 32'h0000_3000;
    step(3);
    freeze = 1'b1;
    step(2);
    cpu_pc = 32'h0000_3004;
    step(2);
    wait_digit("frz_dig0", 8'hFE, 8'hC0);
    wait_digit("frz_dig7", 8'h7F, 8'h40);
    wait_digit("frz_dig3", 8'hF7, 8'hB0);
    freeze = 1'b0;
    step(2);
    wait_digit("unfrz_dig0", 8'hFE, 8'h99);
    wait_digit("unfrz_dig7", 8'h7F, 8'hC0);

    // Long hold gives exactly one step
    sel = 3'd2;
    step(2);
    press(1'b1, 1'b0, 20, 8);
    check("long_hold", {27'b0, rf_addr}, 32'd1);

    // Reset while held: nothing until release and re-press
    btn_up = 1'b1;
    step(10);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(12);
    check("rst_held", {27'b0, rf_addr}, 32'd0);
    btn_up = 1'b0;
    step(8);
    check("rst_held_release", {27'b0, rf_addr}, 32'd0);
    press(1'b1, 1'b0, 6, 8);
    check("rst_held_repress", {27'b0, rf_addr}, 32'd1);

`ifdef DBG_PROBE_DEBOUNCE_EN
    press(1'b1, 1'b0, 2, 8);
    check("deb_glitch", {27'b0, rf_addr}, 32'd1);
    press(1'b1, 1'b0, 4, 8);
    check("deb_hold4", {27'b0, rf_addr}, 32'd2);
`else
    press(1'b1, 1'b0, 1, 8);
    check("nodeb_short", {27'b0, rf_addr}, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
